// File: rtl/sram_dp.sv
// Simple dual-port SRAM: one write port with byte enables, one registered read port,
// hardware clear after reset. Define SRAM_FWD_EN to forward same-address writes to the read port.
module sram_dp #(
  parameter int ADDR   = 8,
  parameter int WIDTH  = 32,
  parameter int LENGTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  output logic               busy,
  input  logic               wr_en,
  input  logic [ADDR-1:0]    wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR-1:0]    rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR-1:0] LAST = ADDR'(LENGTH - 1);
  localparam logic [ADDR:0]   LEN  = (ADDR + 1)'(LENGTH);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_mem [LENGTH];
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_rd_valid;
  logic               w_busy;
  logic               w_wr_in;
  logic               w_rd_in;
  logic               w_rd_acc;
  logic [WIDTH-1:0]   w_old;
  logic [WIDTH-1:0]   w_rd_word;

  // Handshake: a request is taken at any rising edge where its enable is high and busy is low;
  // there is no back-pressure beyond busy.
  assign w_wr_in  = ({1'b0, wr_addr} < LEN);
  assign w_rd_in  = ({1'b0, rd_addr} < LEN);
  assign w_rd_acc = rd_en && !w_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_cnt == LAST) w_state_nxt = S_READY;
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  assign busy = w_busy;

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
  end

  // Storage is never touched by the reset edge itself; only the sequencer clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_busy) begin
        r_mem[r_cnt] <= '0;
      end else if (wr_en && w_wr_in) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign w_old = w_rd_in ? r_mem[rd_addr] : '0;

`ifdef SRAM_FWD_EN
  logic [WIDTH-1:0] w_merged;
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) w_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    w_rd_word = w_old;
    if (wr_en && w_wr_in && w_rd_in && wr_addr == rd_addr) w_rd_word = w_merged;
  end
`else
  always_comb begin
    w_rd_word = w_old;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_rd_word;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp: a 256-word instance plus a 200-word instance for out-of-range cases,
// sharing clock, reset and request inputs.
module tb_sram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic        busy,   busy_o;
  logic [31:0] rd_data, rd_data_o;
  logic        rd_valid, rd_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int nm, no;
  logic [31:0] exp_q[$];
  logic [31:0] exp_col;

  always #5 clk = ~clk;

  sram_dp #(.ADDR(8), .WIDTH(32), .LENGTH(256)) u_dut (
    .clk(clk), .rst(rst), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  sram_dp #(.ADDR(8), .WIDTH(32), .LENGTH(200)) u_oor (
    .clk(clk), .rst(rst), .busy(busy_o),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o), .rd_valid(rd_valid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_m(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic rd_o(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    chk(tag, rd_data_o, exp_q.pop_front());
  endtask

  // Counts samples with busy high on each instance; requests present on entry are held
  // for the whole clear and dropped once both instances report idle.
  task automatic wait_clear(output int n_main, output int n_oor);
    n_main = 0;
    n_oor  = 0;
    for (int i = 0; i < 400 && (busy || busy_o); i++) begin
      if (busy) begin
        n_main++;
        chk("valid_during_clear", 32'(rd_valid), 32'd0);
      end
      if (busy_o) n_oor++;
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    // Reset for two cycles, then the clear must take exactly LENGTH cycles.
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    wait_clear(nm, no);
    chk("clear_cycles", nm, 32'd256);
    chk("clear_cycles_len200", no, 32'd200);
    for (int a = 0; a < 256; a++) rd_m($sformatf("cleared_%0d", a), 8'(a), 32'd0);

    // Byte-lane writes and read hold behaviour.
    wr(8'd5, 32'h1122_3344, 4'b1111);
    wr(8'd5, 32'hAABB_CCDD, 4'b0101);
    rd_m("be_merge", 8'd5, 32'h11BB_33DD);
    tick();
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", rd_data, 32'h11BB_33DD);
    wr(8'd5, 32'hFFFF_FFFF, 4'b0000);
    rd_m("be_zero_noop", 8'd5, 32'h11BB_33DD);

    // Read and write to different addresses in one cycle.
    wr_en = 1'b1; wr_addr = 8'd6; wr_data = 32'h0000_600D; wr_be = 4'b1111;
    rd_m("dual_port_rd", 8'd5, 32'h11BB_33DD);
    wr_en = 1'b0;
    rd_m("dual_port_wr", 8'd6, 32'h0000_600D);

    // Same-address collision.
`ifdef SRAM_FWD_EN
    exp_col = 32'h0000_FFFF;
`else
    exp_col = 32'h0000_0000;
`endif
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hFFFF_FFFF; wr_be = 4'b0011;
    rd_m("collision", 8'd9, exp_col);
    wr_en = 1'b0;
    rd_m("collision_after", 8'd9, 32'h0000_FFFF);

    // Top address boundary.
    wr(8'd255, 32'hC0DE_00FF, 4'b1111);
    rd_m("last_word", 8'd255, 32'hC0DE_00FF);
    rd_m("first_word", 8'd0, 32'd0);

    // Requests held throughout a clear are ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 8'd3;
    wait_clear(nm, no);
    chk("clear_cycles_req", nm, 32'd256);
    rd_m("no_write_in_clear", 8'd3, 32'd0);

    // Reset in the middle of a clear restarts it from word 0.
    wr(8'd200, 32'hCAFE_0200, 4'b1111);
    wr(8'd10, 32'h0A0A_0A0A, 4'b1111);
    rd_m("pre_mid_200", 8'd200, 32'hCAFE_0200);
    rd_m("pre_mid_10", 8'd10, 32'h0A0A_0A0A);
    rst = 1'b1; tick();
    chk("reset_clears_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    repeat (100) tick();
    chk("busy_at_100", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_clear(nm, no);
    chk("clear_cycles_restart", nm, 32'd256);
    rd_m("mid_clear_200", 8'd200, 32'd0);
    rd_m("mid_clear_10", 8'd10, 32'd0);

    // Out-of-range accesses on the 200-word instance.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    wait_clear(nm, no);
    chk("clear_cycles_oor", no, 32'd200);
    wr(8'd199, 32'h5A5A_5A5A, 4'b1111);
    rd_o("oor_last_in_range", 8'd199, 32'h5A5A_5A5A);
    wr_en = 1'b1; wr_addr = 8'd250; wr_data = 32'h1234_5678; wr_be = 4'b1111;
    rd_o("oor_same_cycle", 8'd250, 32'd0);
    wr_en = 1'b0;
    rd_o("oor_read", 8'd250, 32'd0);
    rd_m("in_range_250_main", 8'd250, 32'h1234_5678);
    for (int a = 0; a < 199; a++) rd_o($sformatf("oor_unchanged_%0d", a), 8'(a), 32'd0);
    rd_o("oor_unchanged_199", 8'd199, 32'h5A5A_5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
